// File: rtl/pulse_chk_pkg.sv
// Shared types and widths for the pulse period checker.
package pulse_chk_pkg;

  typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCKED} chk_state_e;

  localparam int ERRCNT_W = 16;

endpackage

// File: rtl/pulse_edge_det.sv
// Gated rising-edge detector; with en low the history is forced to 0 so a level
// already high when en rises is reported as a rise.
module pulse_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic rise
);

  logic pulse_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulse_d <= 1'b0;
    else        pulse_d <= en & din;
  end

  assign rise = en & din & ~pulse_d;

endmodule

// File: rtl/pulse_period_checker.sv
// Periodic pulse checker: measures rise-to-rise interval, locks after LOCK_CNT good
// intervals, strobes early/missing pulses. Define PULSE_CHK_ERRCNT_EN for err_count.
module pulse_period_checker
  import pulse_chk_pkg::*;
#(
  parameter  int PERIOD   = 10,
  parameter  int TOL      = 0,
  parameter  int LOCK_CNT = 4,
  localparam int CW       = $clog2(PERIOD + TOL + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          pulse_in,
  output logic          locked,
  output logic          err_early,
  output logic          err_miss,
  output logic [CW-1:0] period_meas
`ifdef PULSE_CHK_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_count
`endif
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] MIN_GOOD = CW'(PERIOD - TOL);
  localparam logic [CW-1:0] TMO      = CW'(PERIOD + TOL);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT);

  chk_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n, meas_n, ival;
  logic [GW-1:0] good_cnt, good_n;
  logic          early_n, miss_n, rise;

  pulse_edge_det u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .din   (pulse_in),
    .rise  (rise)
  );

  assign ival   = cnt + CW'(1);
  assign locked = (state == LOCKED);

  always_comb begin
    state_n = state;
    // cnt only matters after a reference edge; saturate so ACQ never wraps
    cnt_n   = rise ? '0 : ((cnt == CNT_MAX) ? cnt : ival);
    good_n  = good_cnt;
    meas_n  = period_meas;
    early_n = 1'b0;
    miss_n  = 1'b0;
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      good_n  = '0;
    end else begin
      case (state)
        IDLE: state_n = ACQ;
        ACQ: begin
          if (rise) begin
            state_n = TRACK;
            good_n  = '0;
          end
        end
        TRACK, LOCKED: begin
          if (rise) begin
            meas_n = ival;
            if (ival < MIN_GOOD) begin
              early_n = 1'b1;
              good_n  = '0;
              state_n = TRACK;
            end else begin
              good_n = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GW'(1);
              if (state == TRACK && (good_cnt + GW'(1)) == GOOD_MAX) state_n = LOCKED;
            end
          end else if (ival == TMO) begin
            miss_n  = 1'b1;
            good_n  = '0;
            state_n = ACQ;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      good_cnt    <= '0;
      period_meas <= '0;
      err_early   <= 1'b0;
      err_miss    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      good_cnt    <= good_n;
      period_meas <= meas_n;
      err_early   <= early_n;
      err_miss    <= miss_n;
    end
  end

`ifdef PULSE_CHK_ERRCNT_EN
  // counts in step with the strobes it reports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     err_count <= '0;
    else if ((early_n | miss_n) && err_count != '1) err_count <= err_count + ERRCNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_pulse_period_checker.sv
// Bench: two checkers (TOL=0 and TOL=1) on one stimulus, compared each cycle
// against an interval-arithmetic reference model.
module tb_pulse_period_checker;

  typedef struct {
    int phase;   // 0 idle, 1 hunting, 2 tracking
    bit locked;
    int last;
    int good;
    int meas;
    bit early;
    bit miss;
    int ecnt;
  } mdl_t;

  localparam int P = 10;
  localparam int L = 4;
  localparam int TOLS [2] = '{0, 1};

  logic       clk, rst_n, en, pulse_in;
  logic       locked [2], err_early [2], err_miss [2];
  logic [3:0] pm [2];
`ifdef PULSE_CHK_ERRCNT_EN
  logic [15:0] ecnt [2];
`endif

  mdl_t m [2];
  bit   prev_p;
  int   cyc, n_cmp, n_bad;

  pulse_period_checker #(.PERIOD(P), .TOL(0), .LOCK_CNT(L)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .pulse_in(pulse_in),
    .locked(locked[0]), .err_early(err_early[0]), .err_miss(err_miss[0]),
    .period_meas(pm[0])
`ifdef PULSE_CHK_ERRCNT_EN
    , .err_count(ecnt[0])
`endif
  );

  pulse_period_checker #(.PERIOD(P), .TOL(1), .LOCK_CNT(L)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .pulse_in(pulse_in),
    .locked(locked[1]), .err_early(err_early[1]), .err_miss(err_miss[1]),
    .period_meas(pm[1])
`ifdef PULSE_CHK_ERRCNT_EN
    , .err_count(ecnt[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mdl_t mreset();
    mdl_t r;
    r.phase = 0; r.locked = 0; r.last = 0; r.good = 0;
    r.meas = 0; r.early = 0; r.miss = 0; r.ecnt = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t mi, int tol, bit en_v, bit rise, int n);
    mdl_t r = mi;
    int iv;
    r.early = 0;
    r.miss  = 0;
    if (!en_v) begin
      r.phase = 0; r.locked = 0; r.good = 0;
    end else if (r.phase == 0) begin
      r.phase = 1;
    end else if (r.phase == 1) begin
      if (rise) begin r.phase = 2; r.last = n; r.good = 0; end
    end else begin
      iv = n - r.last;
      if (rise) begin
        r.meas = iv;
        r.last = n;
        if (iv < P - tol) begin
          r.early = 1; r.good = 0; r.locked = 0;
        end else begin
          r.good++;
          if (r.good >= L) r.locked = 1;
        end
      end else if (iv == P + tol) begin
        r.miss = 1; r.phase = 1; r.locked = 0; r.good = 0;
      end
    end
    if (r.early || r.miss) r.ecnt++;
    return r;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === 32'(exp)) else begin
      n_bad++;
      $error("FAIL %s[dut%0d] cyc=%0d observed=%0d expected=%0d", tag, idx, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("locked",      i, 32'(locked[i]),    int'(m[i].locked));
      chk("err_early",   i, 32'(err_early[i]), int'(m[i].early));
      chk("err_miss",    i, 32'(err_miss[i]),  int'(m[i].miss));
      chk("period_meas", i, 32'(pm[i]),        m[i].meas);
`ifdef PULSE_CHK_ERRCNT_EN
      chk("err_count",   i, 32'(ecnt[i]),      m[i].ecnt);
`endif
    end
  endtask

  task automatic tick();
    bit pv, rise;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      pv   = en && (pulse_in === 1'b1);
      rise = pv && !prev_p;
      for (int i = 0; i < 2; i++) m[i] = mstep(m[i], TOLS[i], en, rise, cyc);
      prev_p = pv;
    end else begin
      for (int i = 0; i < 2; i++) m[i] = mreset();
      prev_p = 0;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse(input int gap);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    repeat (gap - 1) tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; prev_p = 0;
    rst_n = 1'b0; en = 1'b0; pulse_in = 1'b0;
    for (int i = 0; i < 2; i++) m[i] = mreset();
    repeat (2) tick();
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (3) tick();

    // lock on a clean 10-cycle stream
    repeat (6) pulse(10);
    chk("t1_locked", 0, 32'(locked[0]), 1);
    chk("t1_meas",   0, 32'(pm[0]), 10);

    // early pulse 7 cycles after the previous one
    pulse(7);
    pulse_in = 1'b1;
    tick();
    chk("t2_early",  0, 32'(err_early[0]), 1);
    chk("t2_meas",   0, 32'(pm[0]), 7);
    chk("t2_unlock", 0, 32'(locked[0]), 0);
    pulse_in = 1'b0;
    repeat (9) tick();
    repeat (5) pulse(10);
    chk("t2_relock", 0, 32'(locked[0]), 1);

    // omitted pulse -> timeout
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    repeat (9) tick();
    tick();
    chk("t3_miss", 0, 32'(err_miss[0]), 1);
    repeat (5) tick();
    repeat (6) pulse(10);

    // tolerance edges, then stuck-high
    pulse(9); pulse(11); pulse(9); pulse(11); pulse(10); pulse(8); pulse(10);
    pulse_in = 1'b1;
    repeat (14) tick();
    pulse_in = 1'b0;
    tick();

    // enable drop with a floating input while locked
    repeat (6) pulse(10);
    en = 1'b0; pulse_in = 1'bx;
    tick();
    chk("t5_unlock", 0, 32'(locked[0]), 0);
    repeat (4) tick();
    en = 1'b1; pulse_in = 1'b0;
    repeat (2) tick();

    // async reset between edges while tracking
    repeat (3) pulse(10);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) m[i] = mreset();
    prev_p = 0;
    check_all();
    chk("t6_meas_rst", 0, 32'(pm[0]), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // randomized mix of all the above
    for (int s = 0; s < 150; s++) begin
      int k;
      k = int'($urandom_range(0, 9));
      if (k <= 4)      pulse(10);
      else if (k == 5) pulse(($urandom_range(0, 1) == 0) ? 9 : 11);
      else if (k == 6) pulse(int'($urandom_range(2, 8)));
      else if (k == 7) begin
        pulse_in = 1'b0;
        repeat (int'($urandom_range(12, 30))) tick();
      end else if (k == 8) begin
        pulse_in = 1'b1;
        repeat (int'($urandom_range(12, 20))) tick();
        pulse_in = 1'b0;
        tick();
      end else begin
        en = 1'b0;
        repeat (int'($urandom_range(1, 5))) begin
          pulse_in = ($urandom_range(0, 2) == 0) ? 1'bx : 1'($urandom_range(0, 1));
          tick();
        end
        en = 1'b1; pulse_in = 1'b0;
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
